dataflow: RTL and testbench
===========================

Name: dataflow

Overview:
- Lane-parallel data-reorganisation stage of the accelerator datapath.
- Takes LANE lanes of 16 signed fixed-point words each, and registers them to the output in one of two layouts:
  - mode 0: pass-through.
  - mode 1: transpose inside each 16-lane group.
- Sits between the compute array and the downstream buffers, so vectors can be re-oriented without a memory round trip.

Parameters:
- IL, 4, integer bits of each fixed-point word.
- FL, 16, fractional bits of each fixed-point word; word width W = IL+FL.
- lane, 512, number of lanes. Must be a positive multiple of 16; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  layout select: 0 = pass-through, 1 = 16x16 block transpose.
- in  input  signed [W-1:0] unpacked [lane-1:0][15:0]  input words; in[l][e] is element e of lane l.
- out  output  signed [W-1:0] unpacked [lane-1:0][15:0]  registered output words.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- While reset=1, every out[l][e] is 0. This holds immediately, with no clock edge needed, and regardless of mode or in, including X.
- Lanes are grouped into blocks of 16: block b covers lanes 16b..16b+15.
- Block count = lane/16.
- Data-path rule, evaluated on each rising clk edge with reset=0 (mode and in are sampled on the same edge):
  - mode=0: out[l][e] <= in[l][e].
  - mode=1: out[16b+r][c] <= in[16b+c][r] for r, c in 0..15.
- Latency is 1 cycle: the output reflects the inputs sampled at the previous edge.
- Results are exact. There is no arithmetic, rounding or sign change, and the full W bits are moved unchanged.
- No handshake. A new word set is accepted every cycle and outputs update every cycle.
- Mode change takes effect on the first edge at which the new value is sampled. There is no drain and no mixing within one cycle.
- Reset asserted mid-operation clears all outputs at once. The first post-reset edge loads fresh data.
- If mode is X while reset=0, the output is don't-care. The bench drives mode to a known value before deasserting reset.
- Blocks are fully independent; no data crosses a 16-lane block boundary.

Optional Feature:
- Macro: DATAFLOW_PIPE2_EN.
- Defined:
  - A second register stage is added after the layout mux.
  - Latency becomes 2 cycles.
  - Both stages clear asynchronously on reset, so out stays 0 for the first two edges after reset release.
- Not defined: single stage, latency 1, as described above.

Test Plan:
1. Reset: reset=1 with random in and mode=1 -> all out = 0 before and after clk edges; release reset -> outputs update from the next edge.
2. Pass-through: mode=0, in[p][q]=p+q -> after 1 edge out[0][k]=k and out[4][k]=4+k for k=0..15; out[511][15]=526.
3. Transpose, asymmetric data: mode=1, in[p][q]=16p+q -> out[0][k]=16k, out[1][3]=49, out[17][2]=16*(16+2)+1=289, out[511][0]=16*496+15=7951.
4. Mode switch: hold in and toggle mode 0->1->0 on consecutive cycles -> each output cycle matches the mode sampled on the preceding edge, with no stale or mixed words.
5. Signed extremes: in[l][e] = -2^(W-1) and 2^(W-1)-1 alternating -> values preserved bit-exact in both modes.
6. Mid-stream reset: assert reset asynchronously between edges while streaming -> out = 0 immediately; with DATAFLOW_PIPE2_EN, also verify 2-cycle latency and two zero cycles after release.

Source files
------------

// File: rtl/dataflow.sv
// Lane-parallel reorganisation stage: registers LANE x 16 words either straight through or
// transposed inside each 16-lane block. Define DATAFLOW_PIPE2_EN for a second output register (latency 2).
module dataflow #(
  parameter int IL   = 4,
  parameter int FL   = 16,
  parameter int lane = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic signed [IL+FL-1:0] in  [lane-1:0][15:0],
  output logic signed [IL+FL-1:0] out [lane-1:0][15:0]
);

  localparam int W      = IL + FL;
  localparam int BLOCKS = lane / 16;

  generate
    if (lane <= 0 || (lane % 16) != 0) begin : g_bad_lane
      $fatal(1, "dataflow: lane must be a positive multiple of 16");
    end
  endgenerate

  logic signed [W-1:0] stage_d [lane-1:0][15:0];
  logic signed [W-1:0] out_d   [lane-1:0][15:0];
  logic signed [W-1:0] out_q   [lane-1:0][15:0];

  // Layout mux; transpose never reaches outside its own 16-lane block.
  always_comb begin
    for (int l = 0; l < lane; l++) begin
      for (int e = 0; e < 16; e++) begin
        stage_d[l][e] = in[l][e];
      end
    end
    if (mode) begin
      for (int b = 0; b < BLOCKS; b++) begin
        for (int r = 0; r < 16; r++) begin
          for (int c = 0; c < 16; c++) begin
            stage_d[16*b+r][c] = in[16*b+c][r];
          end
        end
      end
    end
  end

`ifdef DATAFLOW_PIPE2_EN
  logic signed [W-1:0] stage_q [lane-1:0][15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < lane; l++) begin
        for (int e = 0; e < 16; e++) begin
          stage_q[l][e] <= '0;
        end
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    out_d = stage_q;
  end
`else
  always_comb begin
    out_d = stage_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < lane; l++) begin
        for (int e = 0; e < 16; e++) begin
          out_q[l][e] <= '0;
        end
      end
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_dataflow.sv
// Directed, table-driven bench for dataflow: pass-through, block transpose, signed extremes,
// mode switching and asynchronous reset, for either pipeline depth (DATAFLOW_PIPE2_EN).
module tb_dataflow;

   localparam int IL   = 4;
   localparam int FL   = 16;
   localparam int W    = IL + FL;
   localparam int LANE = 512;
`ifdef DATAFLOW_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam logic signed [W-1:0] MINV = 20'sh80000;
   localparam logic signed [W-1:0] MAXV = 20'sh7FFFF;

   typedef struct {
      int                  pattern;
      logic                modeVal;
      int                  laneIdx;
      int                  elem;
      logic signed [W-1:0] expected;
      string               name;
   } vector_t;

   logic                clock;
   logic                reset;
   logic                modeIn;
   logic signed [W-1:0] inW  [LANE-1:0][15:0];
   logic signed [W-1:0] outW [LANE-1:0][15:0];

   int checks   = 0;
   int failures = 0;

   vector_t vectors [17];

   dataflow #(.IL(IL), .FL(FL), .lane(LANE)) dut (
      .clk   (clock),
      .reset (reset),
      .mode  (modeIn),
      .in    (inW),
      .out   (outW)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pattern 0: p+q, 1: 16p+q, 2: min/max alternating by element, 3: random.
   task automatic fillPattern(input int pattern);
      for (int p = 0; p < LANE; p++) begin
         for (int q = 0; q < 16; q++) begin
            case (pattern)
               0:       inW[p][q] = W'(p + q);
               1:       inW[p][q] = W'(16 * p + q);
               2:       inW[p][q] = (q % 2 == 0) ? MINV : MAXV;
               default: inW[p][q] = W'($urandom);
            endcase
         end
      end
   endtask

   // Drive a pattern and mode on the falling edge, then let it travel through the pipeline.
   task automatic applyStimulus(input int pattern, input logic modeVal);
      @(negedge clock);
      fillPattern(pattern);
      modeIn = modeVal;
      repeat (LAT) @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic signed [W-1:0] actual,
                              input logic signed [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic checkAllZero(input string name);
      int bad = 0;
      logic signed [W-1:0] firstBad = '0;
      for (int l = 0; l < LANE; l++) begin
         for (int e = 0; e < 16; e++) begin
            if (outW[l][e] !== '0) begin
               if (bad == 0) firstBad = outW[l][e];
               bad++;
            end
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL %s nonzero_words=%0d first_actual=%0d expected=0", name, bad, firstBad);
      end
   endtask

   // Full sweep of the 16p+q pattern under transpose: out[16b+r][c] must be 16*(16b+c)+r.
   task automatic checkTransposeAll(input string name);
      int bad = 0;
      int badL = 0;
      int badE = 0;
      logic signed [W-1:0] exp;
      for (int l = 0; l < LANE; l++) begin
         for (int e = 0; e < 16; e++) begin
            exp = W'(16 * ((l / 16) * 16 + e) + (l % 16));
            if (outW[l][e] !== exp) begin
               if (bad == 0) begin
                  badL = l;
                  badE = e;
               end
               bad++;
            end
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL %s bad_words=%0d first_at=[%0d][%0d] actual=%0d expected=%0d", name, bad,
                  badL, badE, outW[badL][badE], W'(16 * ((badL / 16) * 16 + badE) + (badL % 16)));
      end
   endtask

   initial begin
      logic seqMode [4];
      logic expMode;

      vectors[0]  = '{0, 1'b0, 0,   0,  20'sd0,    "pass_l0_e0"};
      vectors[1]  = '{0, 1'b0, 0,   15, 20'sd15,   "pass_l0_e15"};
      vectors[2]  = '{0, 1'b0, 4,   7,  20'sd11,   "pass_l4_e7"};
      vectors[3]  = '{0, 1'b0, 4,   0,  20'sd4,    "pass_l4_e0"};
      vectors[4]  = '{0, 1'b0, 511, 15, 20'sd526,  "pass_l511_e15"};
      vectors[5]  = '{1, 1'b1, 0,   5,  20'sd80,   "tr_l0_e5"};
      vectors[6]  = '{1, 1'b1, 1,   3,  20'sd49,   "tr_l1_e3"};
      vectors[7]  = '{1, 1'b1, 17,  2,  20'sd289,  "tr_l17_e2"};
      vectors[8]  = '{1, 1'b1, 511, 0,  20'sd7951, "tr_l511_e0"};
      vectors[9]  = '{1, 1'b1, 15,  15, 20'sd255,  "tr_l15_e15"};
      vectors[10] = '{1, 1'b1, 16,  1,  20'sd272,  "tr_l16_e1"};
      vectors[11] = '{1, 1'b0, 1,   3,  20'sd19,   "pass16_l1_e3"};
      vectors[12] = '{2, 1'b0, 3,   0,  MINV,      "ext_pass_min"};
      vectors[13] = '{2, 1'b0, 3,   1,  MAXV,      "ext_pass_max"};
      vectors[14] = '{2, 1'b1, 0,   5,  MINV,      "ext_tr_min"};
      vectors[15] = '{2, 1'b1, 1,   4,  MAXV,      "ext_tr_max"};
      vectors[16] = '{2, 1'b1, 510, 3,  MINV,      "ext_tr_l510"};

      // Reset asserted asynchronously before any clock edge, with garbage on the inputs.
      reset  = 1'b0;
      modeIn = 1'b1;
      fillPattern(3);
      #1 reset = 1'b1;
      #1 checkAllZero("reset_no_edge");
      repeat (2) @(posedge clock);
      #1 checkAllZero("reset_with_edges");

      @(negedge clock);
      reset = 1'b0;
      fillPattern(0);
      modeIn = 1'b0;
      @(posedge clock);
      #1 checkOutput("release_edge1", outW[4][7], (LAT == 2) ? 20'sd0 : 20'sd11);
      @(posedge clock);
      #1 checkOutput("release_edge2", outW[4][7], 20'sd11);

      foreach (vectors[i]) begin
         applyStimulus(vectors[i].pattern, vectors[i].modeVal);
         checkOutput(vectors[i].name, outW[vectors[i].laneIdx][vectors[i].elem], vectors[i].expected);
      end

      applyStimulus(1, 1'b1);
      checkTransposeAll("tr_full_sweep");

      // Mode toggles every edge with the data held; each output cycle follows its own sampled mode.
      seqMode = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4 + LAT - 1; i++) begin
         @(negedge clock);
         fillPattern(1);
         modeIn = seqMode[(i < 4) ? i : 3];
         @(posedge clock);
         #1;
         if (i >= LAT - 1) begin
            expMode = seqMode[i - LAT + 1];
            checkOutput($sformatf("switch%0d_l1_e3", i), outW[1][3], expMode ? 20'sd49 : 20'sd19);
            checkOutput($sformatf("switch%0d_l17_e2", i), outW[17][2], expMode ? 20'sd289 : 20'sd274);
         end
      end

      // Reset dropped in between edges while streaming, then fresh data after release.
      applyStimulus(1, 1'b1);
      @(posedge clock);
      #3 reset = 1'b1;
      #1 checkAllZero("midstream_reset");
      @(negedge clock);
      reset = 1'b0;
      fillPattern(0);
      modeIn = 1'b0;
      @(posedge clock);
      #1 checkOutput("post_mid_edge1", outW[511][15], (LAT == 2) ? 20'sd0 : 20'sd526);
      @(posedge clock);
      #1 checkOutput("post_mid_edge2", outW[511][15], 20'sd526);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
